// File: rtl/snn_mon_pkg.sv
// Shared definitions for the SNN inference monitor: FSM encoding, result-entry
// layout helpers and the decimation-period rule.
package snn_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN     = 2'd1,
    ST_WAIT_TGT = 2'd2,
    ST_PUSH     = 2'd3
  } mon_state_e;

  // Result entry layout, LSB first: scores, argmax index, mismatch flag.
  localparam int RES_SCORES_LSB = 0;

  function automatic int res_idx_lsb(input int nch, input int w);
    return nch * w;
  endfunction

  function automatic int res_mis_pos(input int nch, input int w, input int idxw);
    return nch * w + idxw;
  endfunction

  function automatic int res_width(input int nch, input int w, input int idxw);
    return nch * w + idxw + 1;
  endfunction

  // A programmed period of zero behaves as capturing every beat.
  function automatic logic [63:0] decim_step(input logic [63:0] decim);
    logic [63:0] step;
    if (decim == 64'd0) begin
      step = 64'd1;
    end else begin
      step = decim;
    end
    return step;
  endfunction

endpackage

// File: rtl/snn_mon_fifo.sv
// Synchronous result FIFO; a push is accepted while full when a pop frees the
// head slot in the same cycle.
module snn_mon_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          srst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          vld,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          do_push_s, do_pop_s;

  assign vld       = (cnt_r != '0);
  assign full      = (cnt_r == CNT_FULL);
  assign rdata     = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & vld;
  assign do_push_s = push & (~full | do_pop_s);

  // Entry storage, cleared so an empty FIFO presents an all-zero head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (srst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Read/write pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (srst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + (AW + 1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW + 1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/snn_inference_monitor.sv
// On-chip SNN inference monitor: decimated score capture, prediction, target compare,
// counters, error halt and result FIFO. Define SNN_MON_ARGMAX_EN for argmax prediction.
module snn_inference_monitor
  import snn_mon_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int W          = 16,
  parameter int TW         = 26,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32,
  parameter int ERR_W      = 16,
  parameter int IDXW       = $clog2(NCH)
) (
  input  logic                wb_clk,
  input  logic                wb_rst_n,
  input  logic                en_i,
  input  logic [CNT_W-1:0]    decim_i,
  input  logic [ERR_W-1:0]    max_err_i,
  input  logic                beat_vld_i,
  input  logic [NCH*W-1:0]    beat_data_i,
  input  logic                tgt_vld_i,
  input  logic [TW-1:0]       tgt_data_i,
  output logic                tgt_rdy_o,
  output logic                res_vld_o,
  input  logic                res_rdy_i,
  output logic [NCH*W+IDXW:0] res_data_o,
  output logic [CNT_W-1:0]    inf_cnt_o,
  output logic [ERR_W-1:0]    err_cnt_o,
  output logic                halt_o,
  output logic                overrun_o
);
  localparam int RW      = res_width(NCH, W, IDXW);
  localparam int MIS_POS = res_mis_pos(NCH, W, IDXW);
  localparam int IDX_LSB = res_idx_lsb(NCH, W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  mon_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] beat_cnt_r, mark_r, inf_cnt_r, step_s;
  logic [ERR_W-1:0] err_cnt_r, err_nxt_s;
  logic             halt_r, overrun_r, mis_r, mis_s;
  logic [NCH*W-1:0] scores_r;
  logic [IDXW-1:0]  idx_s;
  logic [RW-1:0]    entry_s;
  logic             srst_s, count_en_s, due_s, capture_s, drop_s;
  logic             pop_s, push_s, fifo_full_s;

  assign srst_s     = ~en_i;
  assign step_s     = CNT_W'(decim_step(64'(decim_i)));
  assign count_en_s = beat_vld_i & ~halt_r;
  assign due_s      = count_en_s & (beat_cnt_r == mark_r);
  assign capture_s  = due_s & (state_r == ST_IDLE);
  assign drop_s     = due_s & (state_r != ST_IDLE);
  assign pop_s      = res_vld_o & res_rdy_i;
  assign push_s     = (state_r == ST_PUSH) & (~fifo_full_s | pop_s);

  assign tgt_rdy_o  = (state_r == ST_WAIT_TGT);
  assign inf_cnt_o  = inf_cnt_r;
  assign err_cnt_o  = err_cnt_r;
  assign halt_o     = halt_r;
  assign overrun_o  = overrun_r;

  assign entry_s[MIS_POS]              = mis_r;
  assign entry_s[IDX_LSB +: IDXW]      = idx_s;
  assign entry_s[RES_SCORES_LSB +: NCH*W] = scores_r;

`ifdef SNN_MON_ARGMAX_EN
  logic signed [W-1:0] best_r, cur_s;
  logic [IDXW-1:0]     idx_r, scan_ch_r;
  logic                unused_tgt_s;

  assign cur_s        = scores_r[int'(scan_ch_r) * W +: W];
  assign idx_s        = idx_r;
  assign mis_s        = (idx_r != tgt_data_i[IDXW-1:0]);
  assign unused_tgt_s = ^tgt_data_i[TW-1:IDXW];

  // Running argmax; strict greater-than keeps the lower index on ties
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      best_r    <= '0;
      idx_r     <= '0;
      scan_ch_r <= '0;
    end else if (srst_s) begin
      best_r    <= '0;
      idx_r     <= '0;
      scan_ch_r <= '0;
    end else if (capture_s) begin
      best_r    <= beat_data_i[W-1:0];
      idx_r     <= '0;
      scan_ch_r <= IDXW'(1);
    end else if (state_r == ST_SCAN) begin
      if (cur_s > best_r) begin
        best_r <= cur_s;
        idx_r  <= scan_ch_r;
      end
      scan_ch_r <= scan_ch_r + IDXW'(1);
    end
  end
`else
  logic signed [W-1:0] ch0_s;

  assign ch0_s = scores_r[W-1:0];
  assign idx_s = {IDXW{1'b0}};
  assign mis_s = (TW'(ch0_s) != tgt_data_i);
`endif

  // Saturating error count for the pending result
  always_comb begin
    err_nxt_s = err_cnt_r;
    if (mis_r && (err_cnt_r != ERR_MAX)) begin
      err_nxt_s = err_cnt_r + ERR_ONE;
    end else begin
      err_nxt_s = err_cnt_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
`ifdef SNN_MON_ARGMAX_EN
          state_nxt_s = ST_SCAN;
`else
          state_nxt_s = ST_WAIT_TGT;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
`ifdef SNN_MON_ARGMAX_EN
        if (scan_ch_r == IDXW'(NCH - 1)) begin
          state_nxt_s = ST_WAIT_TGT;
        end else begin
          state_nxt_s = ST_SCAN;
        end
`else
        state_nxt_s = ST_WAIT_TGT;
`endif
      end
      ST_WAIT_TGT: begin
        if (tgt_vld_i) begin
          state_nxt_s = ST_PUSH;
        end else begin
          state_nxt_s = ST_WAIT_TGT;
        end
      end
      ST_PUSH: begin
        if (push_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PUSH;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_r <= ST_IDLE;
    end else if (srst_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Beat counter, capture mark, scores, mismatch and result counters
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      beat_cnt_r <= '0;
      mark_r     <= '0;
      scores_r   <= '0;
      mis_r      <= 1'b0;
      inf_cnt_r  <= '0;
      err_cnt_r  <= '0;
      halt_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else if (srst_s) begin
      beat_cnt_r <= '0;
      mark_r     <= '0;
      scores_r   <= '0;
      mis_r      <= 1'b0;
      inf_cnt_r  <= '0;
      err_cnt_r  <= '0;
      halt_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (count_en_s) beat_cnt_r <= beat_cnt_r + CNT_ONE;
      if (due_s)      mark_r     <= mark_r + step_s;
      if (drop_s)     overrun_r  <= 1'b1;
      if (capture_s)  scores_r   <= beat_data_i;
      if ((state_r == ST_WAIT_TGT) && tgt_vld_i) mis_r <= mis_s;
      if (push_s) begin
        inf_cnt_r <= inf_cnt_r + CNT_ONE;
        err_cnt_r <= err_nxt_s;
        if (err_nxt_s > max_err_i) halt_r <= 1'b1;
      end
    end
  end

  snn_mon_fifo #(
    .DW    (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk),
    .rst_n (wb_rst_n),
    .srst  (srst_s),
    .push  (push_s),
    .wdata (entry_s),
    .pop   (res_rdy_i),
    .rdata (res_data_o),
    .vld   (res_vld_o),
    .full  (fifo_full_s)
  );

endmodule

// File: tb/tb_snn_inference_monitor.sv
// Directed scoreboard bench for snn_inference_monitor (NCH=4); follows SNN_MON_ARGMAX_EN.
module tb_snn_inference_monitor;
  localparam int NCH = 4, W = 16, TW = 26, FD = 4, CNT_W = 32, ERR_W = 16, IDXW = 2;
  localparam int RW = NCH * W + IDXW + 1;

  logic             wb_clk, wb_rst_n, en_i;
  logic [CNT_W-1:0] decim_i;
  logic [ERR_W-1:0] max_err_i;
  logic             beat_vld_i, tgt_vld_i, tgt_rdy_o, res_vld_o, res_rdy_i;
  logic [NCH*W-1:0] beat_data_i;
  logic [TW-1:0]    tgt_data_i;
  logic [RW-1:0]    res_data_o;
  logic [CNT_W-1:0] inf_cnt_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic             halt_o, overrun_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  logic [RW-1:0] sb_q[$];

  snn_inference_monitor #(
    .NCH(NCH), .W(W), .TW(TW), .FIFO_DEPTH(FD), .CNT_W(CNT_W), .ERR_W(ERR_W), .IDXW(IDXW)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .en_i(en_i), .decim_i(decim_i),
    .max_err_i(max_err_i), .beat_vld_i(beat_vld_i), .beat_data_i(beat_data_i),
    .tgt_vld_i(tgt_vld_i), .tgt_data_i(tgt_data_i), .tgt_rdy_o(tgt_rdy_o),
    .res_vld_o(res_vld_o), .res_rdy_i(res_rdy_i), .res_data_o(res_data_o),
    .inf_cnt_o(inf_cnt_o), .err_cnt_o(err_cnt_o), .halt_o(halt_o), .overrun_o(overrun_o)
  );

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // Target value the bench considers a correct prediction for these scores
  function automatic logic [TW-1:0] good_tgt(input logic [NCH*W-1:0] s);
`ifdef SNN_MON_ARGMAX_EN
    logic signed [W-1:0] best, cur;
    int bi;
    best = s[W-1:0];
    bi = 0;
    for (int c = 1; c < NCH; c++) begin
      cur = s[c*W +: W];
      if (cur > best) begin
        best = cur;
        bi = c;
      end
    end
    return TW'(bi);
`else
    logic signed [W-1:0] c0;
    c0 = s[W-1:0];
    return TW'(c0);
`endif
  endfunction

  function automatic logic [TW-1:0] bad_tgt(input logic [NCH*W-1:0] s);
    return good_tgt(s) + TW'(1);
  endfunction

  function automatic logic [RW-1:0] model(input logic [NCH*W-1:0] s, input logic [TW-1:0] t);
    logic [TW-1:0]   g;
    logic [IDXW-1:0] idx;
    logic            mis;
    g = good_tgt(s);
`ifdef SNN_MON_ARGMAX_EN
    idx = g[IDXW-1:0];
    mis = (g[IDXW-1:0] != t[IDXW-1:0]);
`else
    idx = '0;
    mis = (g != t);
`endif
    return {mis, idx, s};
  endfunction

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic beat_only(input logic [NCH*W-1:0] s);
    beat_data_i = s;
    beat_vld_i  = 1'b1;
    tick();
    beat_vld_i  = 1'b0;
  endtask

  task automatic infer(input logic [NCH*W-1:0] s, input logic [TW-1:0] t);
    beat_only(s);
    for (int n = 0; n < 20 && tgt_rdy_o !== 1'b1; n++) tick();
    chk("tgt_rdy_reached", 128'(tgt_rdy_o), 128'(1'b1));
    tgt_data_i = t;
    tgt_vld_i  = 1'b1;
    sb_q.push_back(model(s, t));
    tick();
    tgt_vld_i  = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 80 && sb_q.size() != 0; n++) tick();
    tick();
    chk({tag, "_drain"}, 128'(sb_q.size()), 128'(0));
  endtask

  task automatic wait_vld(input string tag);
    for (int n = 0; n < 30 && res_vld_o !== 1'b1; n++) tick();
    chk({tag, "_vld"}, 128'(res_vld_o), 128'(1'b1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tgt_rdy"}, 128'(tgt_rdy_o), 128'(0));
    chk({tag, "_res_vld"}, 128'(res_vld_o), 128'(0));
    chk({tag, "_res_data"}, 128'(res_data_o), 128'(0));
    chk({tag, "_inf_cnt"}, 128'(inf_cnt_o), 128'(0));
    chk({tag, "_err_cnt"}, 128'(err_cnt_o), 128'(0));
    chk({tag, "_halt"}, 128'(halt_o), 128'(0));
    chk({tag, "_overrun"}, 128'(overrun_o), 128'(0));
  endtask

  task automatic clear(input string tag);
    en_i = 1'b0;
    tick();
    check_zero(tag);
    en_i = 1'b1;
  endtask

  // Scoreboard: compare each result as it leaves the FIFO
  always @(negedge wb_clk) begin
    if (wb_rst_n === 1'b1 && res_vld_o === 1'b1 && res_rdy_i === 1'b1) begin
      n_pop++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_result", 128'(res_data_o), 128'(0));
      end else begin
        chk("result_entry", 128'(res_data_o), 128'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    logic [NCH*W-1:0] s;
    int pop0;

    wb_rst_n = 1'b0; en_i = 1'b0; decim_i = '0; max_err_i = '0;
    beat_vld_i = 1'b0; beat_data_i = '0; tgt_vld_i = 1'b0; tgt_data_i = '0; res_rdy_i = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    wb_rst_n = 1'b1;
    en_i = 1'b1; decim_i = 32'd4; max_err_i = 16'd100; res_rdy_i = 1'b1;
    tick();

    // decim 4 over 12 beats: beats 1, 5 and 9 are captured
    for (int i = 1; i <= 12; i++) begin
      s = pk(i, 2 * i, -i, 3);
      if ((i % 4) == 1) infer(s, good_tgt(s));
      else beat_only(s);
    end
    drain("decim4");
    chk("decim4_inf_cnt", 128'(inf_cnt_o), 128'(3));
    chk("decim4_err_cnt", 128'(err_cnt_o), 128'(0));
    chk("decim4_overrun", 128'(overrun_o), 128'(0));

    clear("clr_a");
    decim_i = 32'd1; res_rdy_i = 1'b0;
`ifdef SNN_MON_ARGMAX_EN
    s = pk(-5, 7, 7, 3);
    infer(s, TW'(2));
    wait_vld("tie");
    chk("tie_idx", 128'(res_data_o[NCH*W +: IDXW]), 128'(1));
    chk("tie_mis", 128'(res_data_o[RW-1]), 128'(1));
`else
    s = pk(-300, 11, 22, 33);
    infer(s, TW'(-300));
    wait_vld("ch0_eq");
    chk("ch0_eq_mis", 128'(res_data_o[RW-1]), 128'(0));
    chk("ch0_idx_zero", 128'(res_data_o[NCH*W +: IDXW]), 128'(0));
    infer(s, TW'(-299));
`endif
    res_rdy_i = 1'b1;
    drain("cmp");
    chk("cmp_err_cnt", 128'(err_cnt_o), 128'(1));

    // Error threshold 2: third mismatch halts
    clear("clr_b");
    max_err_i = 16'd2;
    s = pk(10, -20, 30, 40);   infer(s, bad_tgt(s));
    s = pk(-1, -2, -3, -4);    infer(s, bad_tgt(s));
    drain("halt2");
    chk("pre_halt", 128'(halt_o), 128'(0));
    chk("pre_halt_err", 128'(err_cnt_o), 128'(2));
    s = pk(500, 400, 300, 200); infer(s, bad_tgt(s));
    drain("halt3");
    chk("halt_set", 128'(halt_o), 128'(1));
    chk("halt_err", 128'(err_cnt_o), 128'(3));
    for (int i = 0; i < 3; i++) begin
      beat_only(pk(i, i, i, i));
      repeat (3) tick();
      chk("halted_no_capture", 128'(tgt_rdy_o), 128'(0));
    end
    chk("halted_inf_cnt", 128'(inf_cnt_o), 128'(3));
    chk("halted_fifo_empty", 128'(res_vld_o), 128'(0));

    // FIFO fill with continuous beats and held targets
    clear("clr_c");
    max_err_i = 16'd100; res_rdy_i = 1'b0;
    s = pk(1, 9, 4, 2);
    tgt_data_i = good_tgt(s); tgt_vld_i = 1'b1;
    beat_data_i = s; beat_vld_i = 1'b1;
    repeat (40) tick();
    beat_vld_i = 1'b0;
    repeat (10) tick();
    chk("full_inf_cnt", 128'(inf_cnt_o), 128'(4));
    chk("full_overrun", 128'(overrun_o), 128'(1));
    chk("full_res_vld", 128'(res_vld_o), 128'(1));
    chk("full_stall_push", 128'(tgt_rdy_o), 128'(0));
    tgt_vld_i = 1'b0;
    repeat (5) sb_q.push_back(model(s, good_tgt(s)));
    pop0 = n_pop;
    res_rdy_i = 1'b1;
    repeat (20) tick();
    chk("full_pop_count", 128'(n_pop - pop0), 128'(5));
    chk("full_sb_empty", 128'(sb_q.size()), 128'(0));
    chk("full_inf_final", 128'(inf_cnt_o), 128'(5));

    // Async reset while waiting for a target
    beat_only(pk(3, 2, 1, 0));
    for (int n = 0; n < 20 && tgt_rdy_o !== 1'b1; n++) tick();
    chk("rst_wait_reached", 128'(tgt_rdy_o), 128'(1));
    wb_rst_n = 1'b0;
    #2;
    check_zero("rst_mid_wait");
    tick();
    wb_rst_n = 1'b1;
    tick();
    s = pk(-7, -8, 6, -9);
    infer(s, good_tgt(s));
    drain("after_rst");
    chk("after_rst_inf", 128'(inf_cnt_o), 128'(1));

    // Enable dropped during the scan with a result still queued
    res_rdy_i = 1'b0;
    s = pk(2, 2, 2, 2);
    infer(s, good_tgt(s));
    wait_vld("pre_clr");
    beat_only(pk(5, 6, 7, 8));
    en_i = 1'b0;
    tick();
    check_zero("en_low_scan");
    sb_q.delete();
    en_i = 1'b1; res_rdy_i = 1'b1;
    s = pk(0, -1, 100, 99);
    infer(s, good_tgt(s));
    drain("after_en");
    chk("after_en_inf", 128'(inf_cnt_o), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
